lsu_align_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 33 +++
 rtl/lsu_align_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes,
// FSM state encoding and the access-size decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic       sext;
    logic [2:0] nbytes;
  } size_dec_t;

  // Unsigned loads have no store counterpart, so they are legal only for loads.
  function automatic size_dec_t size_decode(input logic we, input logic [2:0] funct3);
    size_dec_t d;
    d = '0;
    case (funct3)
      F3_B:    d = '{legal: 1'b1, sext: 1'b1, nbytes: 3'd1};
      F3_H:    d = '{legal: 1'b1, sext: 1'b1, nbytes: 3'd2};
      F3_W:    d = '{legal: 1'b1, sext: 1'b0, nbytes: 3'd4};
      F3_BU:   d = '{legal: ~we,  sext: 1'b0, nbytes: 3'd1};
      F3_HU:   d = '{legal: ~we,  sext: 1'b0, nbytes: 3'd2};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane geometry: byte enables across two words, shifted store data and
// the extracted, extended load result from the two read buffers.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  n,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_buf,
  input  logic [31:0] hi_buf,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic [31:0] load_data
);

  logic [7:0]  mask;
  logic [31:0] raw;

  always_comb begin
    mask      = (8'd1 << n) - 8'd1;
    be8       = mask << off;
    wd64      = {32'b0, wdata} << {off, 3'b000};
    raw       = 32'({hi_buf, lo_buf} >> {off, 3'b000});
    load_data = raw;
    case (n)
      3'd1:    load_data = sext ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
      3'd2:    load_data = sext ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store unit: splits byte/half/word requests into one or two aligned
// word accesses and returns extended load data with a one-cycle response.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 64,
  parameter int MEM_AW     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_wr_en,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  lsu_state_e state_q, state_d;

  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic              legal_q, legal_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        off_q, off_d;
  logic [MEM_AW-1:0] w0_q, w0_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_buf_q, lo_buf_d;
  logic [31:0]       hi_buf_q, hi_buf_d;
  logic [31:0]       rdata_hold_q, rdata_hold_d;
  logic              err_hold_q, err_hold_d;

  logic              accept;
  size_dec_t         dec;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [31:0]       load_data;
  logic [31:0]       resp_now;
  logic              crossing;
  logic [MEM_AW-1:0] w1;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:MEM_AW+2];

  assign accept   = req_valid && req_ready;
  assign dec      = size_decode(req_we, req_funct3);
  assign crossing = |be8[7:4];
  assign w1       = (w0_q == MEM_AW'(MEM_WORDS - 1)) ? '0 : w0_q + 1'b1;
  assign resp_now = (we_q || !legal_q) ? '0 : load_data;

  lsu_lane_align u_lane (
    .off       (off_q),
    .n         (n_q),
    .sext      (sext_q),
    .wdata     (wdata_q),
    .lo_buf    (lo_buf_q),
    .hi_buf    (hi_buf_q),
    .be8       (be8),
    .wd64      (wd64),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = dec.legal ? FIRST : RESP;
      FIRST:   state_d = crossing ? SECOND : RESP;
      SECOND:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data is live from the buffers in RESP and held afterwards.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = (state_q == RESP) ? resp_now : rdata_hold_q;
    resp_err   = (state_q == RESP) ? ~legal_q : err_hold_q;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state_q)
      FIRST: begin
        mem_addr  = w0_q;
        mem_be    = be8[3:0];
        mem_wdata = wd64[31:0];
      end
      SECOND: begin
        mem_addr  = w1;
        mem_be    = be8[7:4];
        mem_wdata = wd64[63:32];
      end
      default: ;
    endcase
    mem_wr_en = we_q && (mem_be != 4'b0000);
  end

  always_comb begin
    we_d         = we_q;
    sext_d       = sext_q;
    legal_d      = legal_q;
    n_d          = n_q;
    off_d        = off_q;
    w0_d         = w0_q;
    wdata_d      = wdata_q;
    lo_buf_d     = lo_buf_q;
    hi_buf_d     = hi_buf_q;
    rdata_hold_d = rdata_hold_q;
    err_hold_d   = err_hold_q;
    if (accept) begin
      we_d    = req_we;
      sext_d  = dec.sext;
      legal_d = dec.legal;
      n_d     = dec.nbytes;
      off_d   = req_addr[1:0];
      w0_d    = req_addr[MEM_AW+1:2];
      wdata_d = req_wdata;
    end
    case (state_q)
      FIRST:  lo_buf_d = mem_rdata;
      SECOND: hi_buf_d = mem_rdata;
      RESP: begin
        rdata_hold_d = resp_now;
        err_hold_d   = ~legal_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      sext_q       <= 1'b0;
      legal_q      <= 1'b0;
      n_q          <= '0;
      off_q        <= '0;
      w0_q         <= '0;
      wdata_q      <= '0;
      lo_buf_q     <= '0;
      hi_buf_q     <= '0;
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      sext_q       <= sext_d;
      legal_q      <= legal_d;
      n_q          <= n_d;
      off_q        <= off_d;
      w0_q         <= w0_d;
      wdata_q      <= wdata_d;
      lo_buf_q     <= lo_buf_d;
      hi_buf_q     <= hi_buf_d;
      rdata_hold_q <= rdata_hold_d;
      err_hold_q   <= err_hold_d;
    end
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Bench for lsu_align_ctrl: word memory model, byte-addressed reference
// model, directed scenarios and randomized requests.
module tb_lsu_align_ctrl;

  localparam int AW = 32;
  localparam int MW = 64;
  localparam int MAW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [MAW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [MW];
  logic [7:0]  ref_b [MW*4];
  logic [10:0] acc_q [$];
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] wr_word;

  always #5 clk = ~clk;

  lsu_align_ctrl #(.ADDR_WIDTH(AW), .MEM_WORDS(MW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_be != 4'b0000) acc_q.push_back({mem_wr_en, mem_addr, mem_be});
    if (req_valid && req_ready) acc_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      wr_word = mem[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) wr_word[8*i +: 8] = mem_wdata[8*i +: 8];
      mem[mem_addr] = wr_word;
    end
  end

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 < 3'd3) : (f3 != 3'd3 && f3 < 3'd6);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int unsigned idx;
    v = '0;
    for (int i = 0; i < nbytes(f3); i++) begin
      idx = (int'(a[7:0]) + i) % (MW * 4);
      v = v | (32'(ref_b[idx]) << (8 * i));
    end
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int unsigned idx;
    for (int i = 0; i < nbytes(f3); i++) begin
      idx = (int'(a[7:0]) + i) % (MW * 4);
      ref_b[idx] = wd[8*i +: 8];
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_b[4*w + i] = v[8*i +: 8];
  endtask

  task automatic preset();
    for (int w = 0; w < MW; w++) set_word(w, 32'h0);
    set_word(0, 32'h4433_2211);
    set_word(1, 32'h8877_6655);
    set_word(2, 32'h0000_00CC);
    set_word(63, 32'h1122_3344);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int waitc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waitc = 0;
    while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: got no resp_valid within %0d cycles", lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_wr_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 1000", {req_ready, resp_valid, resp_err, mem_wr_en});
    end
    n_checks++;
    if ({resp_rdata, mem_wdata, mem_be, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata %h wdata %h be %b addr %0d required all 0",
               resp_rdata, mem_wdata, mem_be, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_load();
    logic [31:0] rd; logic er; int lat;
    preset();
    acc_q.delete();
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, rd, er, lat);
    n_checks++;
    if ({rd, er} !== {32'h4433_2211, 1'b0}) begin
      n_fail++; $display("FAIL lw0_data: got %h err %b required 44332211 err 0", rd, er);
    end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw0_latency: got %0d required 2", lat); end
    n_checks++;
    if (acc_q.size() != 1 || acc_q[0] !== {1'b0, 6'd0, 4'b1111}) begin
      n_fail++; $display("FAIL lw0_access: got %0d accesses first %h required 1 access 00f", acc_q.size(),
                         (acc_q.size() > 0) ? acc_q[0] : 11'h0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_rdata} !== {1'b0, 32'h4433_2211}) begin
      n_fail++; $display("FAIL resp_hold: got valid %b data %h required 0 44332211", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_crossing_load();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] ta [4];
    logic [2:0]  tf [4];
    logic [31:0] te [4];
    int          tl [4];
    ta = '{32'h3, 32'h7, 32'h7, 32'h7};
    tf = '{3'b010, 3'b001, 3'b101, 3'b000};
    te = '{32'h7766_5544, 32'hFFFF_CC88, 32'h0000_CC88, 32'hFFFF_FF88};
    tl = '{3, 3, 3, 2};
    preset();
    for (int i = 0; i < 4; i++) begin
      acc_q.delete();
      do_req(1'b0, tf[i], ta[i], 32'h0, rd, er, lat);
      n_checks++;
      if ({rd, er} !== {te[i], 1'b0} || lat !== tl[i]) begin
        n_fail++;
        $display("FAIL cross_load_%0d: got %h err %b lat %0d required %h err 0 lat %0d",
                 i, rd, er, lat, te[i], tl[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (acc_q.size() != 2 || acc_q[0] !== {1'b0, 6'd0, 4'b1000} || acc_q[1] !== {1'b0, 6'd1, 4'b0111}) begin
          n_fail++; $display("FAIL cross_access: got %0d accesses required 2 (w0 be 1000, w1 be 0111)", acc_q.size());
        end
      end
    end
  endtask

  task automatic test_store_split();
    logic [31:0] rd; logic er; int lat;
    preset();
    acc_q.delete();
    do_req(1'b1, 3'b010, 32'h6, 32'hAABB_CCDD, rd, er, lat);
    n_checks++;
    if ({rd, er} !== 33'h0 || lat !== 3) begin
      n_fail++; $display("FAIL sw_resp: got %h err %b lat %0d required 0 err 0 lat 3", rd, er, lat);
    end
    n_checks++;
    if (acc_q.size() != 2 || acc_q[0] !== {1'b1, 6'd1, 4'b1100} || acc_q[1] !== {1'b1, 6'd2, 4'b0011}) begin
      n_fail++; $display("FAIL sw_access: got %0d accesses required 2 (w1 be 1100, w2 be 0011)", acc_q.size());
    end
    n_checks++;
    if ({mem[1], mem[2]} !== {32'hCCDD_6655, 32'h0000_AABB}) begin
      n_fail++; $display("FAIL sw_mem: got %h %h required ccdd6655 0000aabb", mem[1], mem[2]);
    end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hCCDD_6655) begin
      n_fail++; $display("FAIL sw_readback: got %h required ccdd6655", rd);
    end
  endtask

  task automatic test_wrap_illegal();
    logic [31:0] rd; logic er; int lat; int wr0;
    preset();
    acc_q.delete();
    do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h2211_1122 || lat !== 3) begin
      n_fail++; $display("FAIL wrap_load: got %h lat %0d required 22111122 lat 3", rd, lat);
    end
    n_checks++;
    if (acc_q.size() != 2 || acc_q[0][9:4] !== 6'd63 || acc_q[1][9:4] !== 6'd0) begin
      n_fail++; $display("FAIL wrap_access: got %0d accesses required words 63 then 0", acc_q.size());
    end
    wr0 = wr_cnt;
    acc_q.delete();
    do_req(1'b1, 3'b011, 32'h4, 32'hDEAD_BEEF, rd, er, lat);
    n_checks++;
    if ({rd, er} !== {32'h0, 1'b1} || lat !== 1) begin
      n_fail++; $display("FAIL illegal_resp: got %h err %b lat %0d required 0 err 1 lat 1", rd, er, lat);
    end
    n_checks++;
    if (wr_cnt != wr0 || acc_q.size() != 0) begin
      n_fail++; $display("FAIL illegal_noaccess: got %0d writes %0d accesses required 0 0", wr_cnt - wr0, acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    preset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h6; req_wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_second_wr: got %b required 1", mem_wr_en); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wr: got %b required 0", mem_wr_en); end
    rv_seen = 0;
    repeat (2) begin @(negedge clk); if (resp_valid) rv_seen++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (resp_valid) rv_seen++; end
    n_checks++;
    if (rv_seen != 0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_resp: got %0d responses ready %b required 0 ready 1", rv_seen, req_ready);
    end
    n_checks++;
    if ({mem[1], mem[2]} !== {32'hCCDD_6655, 32'h0000_00CC}) begin
      n_fail++; $display("FAIL mid_reset_mem: got %h %h required ccdd6655 000000cc", mem[1], mem[2]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    acc_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (acc_cnt != 2) begin n_fail++; $display("FAIL held_valid_accepts: got %0d required 2", acc_cnt); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp; logic er, we, lg; logic [2:0] f3; int lat, elat, ewr, wr0, bad;
    for (int w = 0; w < MW; w++) set_word(w, $urandom);
    for (int it = 0; it < 250; it++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      wd = $urandom;
      lg = is_legal(we, f3);
      exp = (lg && !we) ? ref_load(a, f3) : 32'h0;
      elat = !lg ? 1 : ((int'(a[1:0]) + nbytes(f3) > 4) ? 3 : 2);
      ewr = (lg && we) ? elat - 1 : 0;
      if (lg && we) ref_store(a, f3, wd);
      wr0 = wr_cnt;
      do_req(we, f3, a, wd, rd, er, lat);
      n_checks++;
      if ({rd, er} !== {exp, ~lg} || lat !== elat || (wr_cnt - wr0) != ewr) begin
        n_fail++;
        $display("FAIL rand_%0d we %b f3 %0d addr %h: got %h err %b lat %0d wr %0d required %h err %b lat %0d wr %0d",
                 it, we, f3, a, rd, er, lat, wr_cnt - wr0, exp, ~lg, elat, ewr);
      end
      if (lg && we) begin
        bad = 0;
        for (int w = 0; w < MW; w++)
          if (mem[w] !== {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]}) bad++;
        n_checks++;
        if (bad != 0) begin
          n_fail++; $display("FAIL rand_mem_%0d: got %0d differing words required 0", it, bad);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned_load();
    test_crossing_load();
    test_store_split();
    test_wrap_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
